// File: rtl/spike_evt_pkg.sv
// Shared definitions for the spike event sequencer.
// Holds the sequencer FSM state encoding and the default widths and depths.
package spike_evt_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_QDEPTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

endpackage

// File: rtl/spike_len_fifo.sv
// Header-length queue for the spike event sequencer.
// Stores packet counts of pending image headers in arrival order.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset (empties the queue)
//   i_push  - write i_din at the tail (ignored when full unless popping)
//   i_din   - packet count to enqueue
//   i_pop   - drop the head entry (ignored when empty)
//   o_full  - QDEPTH entries held
//   o_empty - no entries held
//   o_head  - packet count at the head of the queue
module spike_len_fifo #(
  parameter int CNT_W  = 8,
  parameter int QDEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_push,
  input  logic [CNT_W-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_head
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [CNT_W-1:0] r_mem [QDEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_cnt == CW'(QDEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_head    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage holds data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/spike_event_sequencer.sv
// Spike event sequencer.
// Queues image headers seen on a Wishbone slave port and counts the packet
// beats of each image, flagging the last packet and pulsing on completion.
// Ports:
//   wb_clk_i            - clock, rising edge
//   wb_rst_ni           - synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i- Wishbone cycle, strobe, write enable
//   image_spike_event_i - current beat is an image header
//   image_num_packets_i - packet count N carried by a header
//   clear_err_i         - clear sticky error flags
//   last_image_packet_o - next packet beat is the last of the active image
//   image_done_o        - one-cycle pulse per completed image
//   busy_o              - counting packets of an active image
//   remaining_o         - packets still expected (0 when idle)
//   q_full_o, q_empty_o - header queue status
//   overflow_err_o      - sticky: header dropped on a full queue
//   stray_err_o         - sticky: packet beat arrived while idle
module spike_event_sequencer
  import spike_evt_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic             image_spike_event_i,
  input  logic [CNT_W-1:0] image_num_packets_i,
  input  logic             clear_err_i,
  output logic             last_image_packet_o,
  output logic             image_done_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] remaining_o,
  output logic             q_full_o,
  output logic             q_empty_o,
  output logic             overflow_err_o,
  output logic             stray_err_o
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_ovf;
  logic             r_stray;

  logic             w_hdr;
  logic             w_pkt;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_head;
  logic             w_ovf_evt;
  logic             w_stray_evt;

  // A header beat takes priority over a packet beat in the same cycle.
  assign w_hdr = wbs_cyc_i & wbs_stb_i & image_spike_event_i;
  assign w_pkt = wbs_cyc_i & wbs_stb_i & wbs_we_i & ~image_spike_event_i;

  assign w_push      = w_hdr & (~w_full | w_pop);
  assign w_ovf_evt   = w_hdr & ~w_push;
  // The load cycle is still IDLE, so a packet there is also stray.
  assign w_stray_evt = w_pkt & (r_state == ST_IDLE);

  spike_len_fifo #(
    .CNT_W  (CNT_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .i_push  (w_push),
    .i_din   (image_num_packets_i),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head != '0) begin
            w_state_nxt = ST_COUNT;
            w_rem_nxt   = w_head;
          end else begin
            // Zero-length image completes without ever counting.
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_COUNT: begin
        if (w_pkt) begin
          // Guard on <=1 so remaining never wraps below zero.
          if (r_remaining <= CNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_rem_nxt = r_remaining - CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rem_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      r_done      <= w_done_nxt;
      // A new error event outranks a simultaneous clear.
      r_ovf       <= (r_ovf   & ~clear_err_i) | w_ovf_evt;
      r_stray     <= (r_stray & ~clear_err_i) | w_stray_evt;
    end
  end

  assign busy_o              = (r_state == ST_COUNT);
  assign last_image_packet_o = (r_state == ST_COUNT) & (r_remaining == CNT_W'(1));
  assign image_done_o        = r_done;
  assign remaining_o         = r_remaining;
  assign q_full_o            = w_full;
  assign q_empty_o           = w_empty;
  assign overflow_err_o      = r_ovf;
  assign stray_err_o         = r_stray;

endmodule
